// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// the divider helper used to derive the sample-tick period.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_t;

  // Clock cycles per oversample tick (integer division, rounds down).
  function automatic int uart_sample_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so idle-high lines come out of reset idle.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; the first stage may go metastable, the second filters it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: preset to the line's idle level so leaving reset never looks like an edge.
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver. Each bit is decided by a 2-of-3 vote over
// samples 7, 8 and 9; the stop bit is judged at sample 9 and the receiver
// returns to idle there, so the next start edge may arrive half a bit early.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       busy
);

  localparam int SAMPLE_DIV = uart_sample_div(CLK_FREQ, BAUD);
  localparam int DIV_W      = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BIT_W      = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [3:0]       S_VOTE_A = 4'd7;
  localparam logic [3:0]       S_VOTE_B = 4'd8;
  localparam logic [3:0]       S_DECIDE = 4'd9;
  localparam logic [3:0]       S_LAST   = 4'd15;
  localparam logic             ODD      = (PARITY_ODD != 0);
  localparam rx_state_t        AFTER_DATA = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;

  if (SAMPLE_DIV < 2) begin : g_bad_div
    $error("uart_rx_os: CLK_FREQ/(BAUD*16) must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
    $error("uart_rx_os: DATA_BITS must be in 5..8");
  end

  rx_state_t              state;
  logic                   rxs;
  logic [DIV_W-1:0]       div;
  logic [3:0]             s;
  logic                   samp_a;
  logic                   samp_b;
  logic [DATA_BITS-1:0]   shreg;
  logic [BIT_W-1:0]       bit_idx;
  logic                   perr;
  logic                   tick;
  logic                   vote;
  logic                   decide;
  logic                   bit_end;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  assign tick    = (div == DIV_LAST);
  assign decide  = tick && (s == S_DECIDE);
  assign bit_end = tick && (s == S_LAST);
  // Majority of samples 7 and 8 (held) and sample 9 (live on the decide tick).
  assign vote    = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign busy    = (state != ST_IDLE) || !rxs;

  // Receiver FSM with its divider, sample counter, shift register and output pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      div        <= '0;
      s          <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      shreg      <= '0;
      bit_idx    <= '0;
      perr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;

      if (state == ST_IDLE || state == ST_BRK_WAIT) begin
        div <= '0;
        s   <= '0;
      end else if (tick) begin
        div <= '0;
        s   <= s + 1'b1;
      end else begin
        div <= div + 1'b1;
      end

      if (tick && s == S_VOTE_A) samp_a <= rxs;
      if (tick && s == S_VOTE_B) samp_b <= rxs;

      // NOTE: a later nonblocking assignment to the same register in this block wins,
      // so the state arms below may override the counter updates above.
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            // The first low cycle already counts as divider step 0.
            state   <= ST_START;
            div     <= DIV_ONE;
            bit_idx <= '0;
            perr    <= 1'b0;
          end
        end
        ST_START: begin
          if (decide && vote) state <= ST_IDLE;
          else if (bit_end)   state <= ST_DATA;
        end
        ST_DATA: begin
          if (decide) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
          end else if (bit_end) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) state <= AFTER_DATA;
          end
        end
        ST_PARITY: begin
          if (decide)       perr  <= vote ^ (^shreg) ^ ODD;
          else if (bit_end) state <= ST_STOP;
        end
        ST_STOP: begin
          if (decide) begin
            if (vote) begin
              rx_data    <= 8'(shreg);
              rx_valid   <= 1'b1;
              parity_err <= perr;
              state      <= ST_IDLE;
            end else if (shreg == '0 && !rxs) begin
              break_det <= 1'b1;
              state     <= ST_BRK_WAIT;
            end else begin
              rx_data    <= 8'(shreg);
              rx_valid   <= 1'b1;
              parity_err <= perr;
              frame_err  <= 1'b1;
              state      <= ST_IDLE;
            end
          end
        end
        ST_BRK_WAIT: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
